// File: rtl/lab1_imul_driver_pkg.sv
// Shared types and helpers for the lab1 multiplier stream driver:
// FSM state encoding, the operand LFSR step function and trace formatting.
package lab1_imul_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Right-shifting Galois LFSR; the tap mask is folded in when bit 0 falls out.
   function automatic logic [31:0] lfsr32_next(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
   endfunction

   function automatic logic [63:0] hex8(input logic [31:0] v);
      logic [63:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         s[i*8 +: 8] = hex_char(v[i*4 +: 4]);
      end
      return s;
   endfunction

endpackage

// File: rtl/lab1_imul_lfsr32.sv
// 32-bit operand generator: loads a seed on request and advances one LFSR
// step per accepted request; holds otherwise.
module lab1_imul_lfsr32
   import lab1_imul_driver_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] q
);

   logic [31:0] q_q;
   logic [31:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (step) begin
         q_d = lfsr32_next(q_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 32'h0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/lab1_imul_stream_driver.sv
// Self-test initiator/sink for a lab1 multiplier: streams LFSR operand pairs,
// one outstanding at a time, and checks each product against a*b.
module lab1_imul_stream_driver
   import lab1_imul_driver_pkg::*;
#(
   parameter int unsigned NUM_MSGS   = 16,
   parameter logic [31:0] A_SEED     = 32'h0000_0002,
   parameter logic [31:0] B_SEED     = 32'h0000_0003,
   parameter int unsigned SINK_DELAY = 0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   output logic        istream_val,
   input  logic        istream_rdy,
   output logic [63:0] istream_msg,
   input  logic        ostream_val,
   output logic        ostream_rdy,
   input  logic [31:0] ostream_msg,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] msg_count
);

   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [31:0] A_SEED_EFF = (A_SEED == 32'h0) ? 32'h1 : A_SEED;
   localparam logic [31:0] B_SEED_EFF = (B_SEED == 32'h0) ? 32'h1 : B_SEED;
   localparam logic [7:0]  DLY_INIT   = 8'(SINK_DELAY);
   localparam logic [16:0] LAST_MSG   = 17'(NUM_MSGS);

   state_e      state_q, state_d;
   logic [31:0] exp_q, exp_d;
   logic [7:0]  dly_q, dly_d;
   logic [15:0] err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        lfsr_load;
   logic        lfsr_step;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] prod;

   lab1_imul_lfsr32 u_lfsr_a (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (A_SEED_EFF),
      .q     (opa)
   );

   lab1_imul_lfsr32 u_lfsr_b (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (B_SEED_EFF),
      .q     (opb)
   );

   assign prod = opa * opb;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      dly_d     = dly_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               lfsr_load = 1'b1;
               err_d     = 16'h0;
               cnt_d     = 16'h0;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (istream_rdy) begin
               exp_d     = prod;
               lfsr_step = 1'b1;
               dly_d     = DLY_INIT;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dly_q != 8'h0) begin
               dly_d = dly_q - 8'h1;
            end else if (ostream_val) begin
               cnt_d = cnt_q + 16'h1;
               if ((ostream_msg != exp_q) && (err_q != 16'hFFFF)) begin
                  err_d = err_q + 16'h1;
               end
               state_d = (({1'b0, cnt_q} + 17'h1) == LAST_MSG) ? ST_DONE : ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         exp_q   <= 32'h0;
         dly_q   <= 8'h0;
         err_q   <= 16'h0;
         cnt_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         dly_q   <= dly_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode only registered state, never the incoming handshakes.
   assign istream_val = (state_q == ST_SEND);
   assign istream_msg = {opa, opb};
   assign ostream_rdy = (state_q == ST_WAIT) && (dly_q == 8'h0);
   assign done        = (state_q == ST_DONE);
   assign pass        = done && (err_q == 16'h0);
   assign err_count   = err_q;
   assign msg_count   = cnt_q;

   // Line-trace text: state letter, request/response marks (* fire, # stall), exp:msg.
   function automatic logic [175:0] display_trace();
      logic [7:0] st_chr;
      logic [7:0] in_mark;
      logic [7:0] out_mark;
      case (state_q)
         ST_IDLE: st_chr = "I";
         ST_SEND: st_chr = "S";
         ST_WAIT: st_chr = "W";
         default: st_chr = "D";
      endcase
      in_mark  = istream_val ? (istream_rdy ? "*" : "#") : ".";
      out_mark = ostream_val ? (ostream_rdy ? "*" : "#") : ".";
      return {st_chr, 8'h20, in_mark, out_mark, 8'h20, hex8(exp_q), 8'h3a, hex8(ostream_msg)};
   endfunction

endmodule

// File: tb/tb_lab1_imul_stream_driver.sv
// Directed bench: two driver instances (4 msgs / no delay, 1 msg / delay 5)
// with a mock multiplier; expected requests come from a bench-side LFSR model.
module tb_lab1_imul_stream_driver;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_go, a_ival, a_irdy, a_oval, a_ordy, a_done, a_pass;
   logic [63:0] a_imsg;
   logic [31:0] a_omsg;
   logic [15:0] a_err, a_cnt;

   logic        b_go, b_ival, b_irdy, b_oval, b_ordy, b_done, b_pass;
   logic [63:0] b_imsg;
   logic [31:0] b_omsg;
   logic [15:0] b_err, b_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] req_q[$];

   always #5 clk = ~clk;

   lab1_imul_stream_driver #(
      .NUM_MSGS(4), .A_SEED(32'h2), .B_SEED(32'h3), .SINK_DELAY(0)
   ) dut_a (
      .clk(clk), .reset(reset), .go(a_go),
      .istream_val(a_ival), .istream_rdy(a_irdy), .istream_msg(a_imsg),
      .ostream_val(a_oval), .ostream_rdy(a_ordy), .ostream_msg(a_omsg),
      .done(a_done), .pass(a_pass), .err_count(a_err), .msg_count(a_cnt)
   );

   lab1_imul_stream_driver #(
      .NUM_MSGS(1), .A_SEED(32'h2), .B_SEED(32'h3), .SINK_DELAY(5)
   ) dut_b (
      .clk(clk), .reset(reset), .go(b_go),
      .istream_val(b_ival), .istream_rdy(b_irdy), .istream_msg(b_imsg),
      .ostream_val(b_oval), .ostream_rdy(b_ordy), .ostream_msg(b_omsg),
      .done(b_done), .pass(b_pass), .err_count(b_err), .msg_count(b_cnt)
   );

   function automatic logic [31:0] model_next(input logic [31:0] x);
      logic [31:0] r;
      r = x >> 1;
      if (x[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input logic [31:0] sa, input logic [31:0] sb, input int n);
      logic [31:0] x;
      logic [31:0] y;
      x = sa;
      y = sb;
      req_q.delete();
      for (int i = 0; i < n; i++) begin
         req_q.push_back({x, y});
         x = model_next(x);
         y = model_next(y);
      end
   endtask

   // One request/response on instance A; the mock returns product ^ corrupt.
   task automatic a_xact(input logic [31:0] corrupt, input int stall, input logic go_during);
      logic [63:0] req;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] prod;
      req  = (req_q.size() != 0) ? req_q.pop_front() : 64'h0;
      opa  = req[63:32];
      opb  = req[31:0];
      prod = opa * opb;
      for (int k = 0; k < 20 && !a_ival; k++) tick();
      check("a_ival_wait", {63'h0, a_ival}, 64'h1);
      check("a_req", a_imsg, req);
      a_go = go_during;
      for (int k = 0; k < stall; k++) begin
         tick();
         check("a_stall_val", {63'h0, a_ival}, 64'h1);
         check("a_stall_msg", a_imsg, req);
      end
      a_go   = 1'b0;
      a_irdy = 1'b1;
      tick();
      a_irdy = 1'b0;
      check("a_after_req", {62'h0, a_ival, a_ordy}, 64'h1);
      a_oval = 1'b1;
      a_omsg = prod ^ corrupt;
      tick();
      a_oval = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      a_go = 1'b0; a_irdy = 1'b0; a_oval = 1'b0; a_omsg = 32'h0;
      b_go = 1'b0; b_irdy = 1'b0; b_oval = 1'b0; b_omsg = 32'h0;
      tick(); tick(); tick();
      check("rst_flags", {60'h0, a_ival, a_ordy, a_done, a_pass}, 64'h0);
      check("rst_imsg", a_imsg, 64'h0);
      check("rst_counts", {32'h0, a_err, a_cnt}, 64'h0);
      reset = 1'b0;
      tick();

      // Run 1: four clean messages; first request stalled 10 cycles.
      push_run(32'h2, 32'h3, 4);
      a_go = 1'b1; tick(); a_go = 1'b0;
      check("go_to_val", {63'h0, a_ival}, 64'h1);
      a_xact(32'h0, 10, 1'b0);
      check("second_req", a_imsg, 64'h0000_0001_8020_0002);
      a_xact(32'h0, 0, 1'b0);
      a_xact(32'h0, 2, 1'b1);
      a_xact(32'h0, 0, 1'b0);
      check("run1_done", {62'h0, a_done, a_pass}, 64'h3);
      check("run1_counts", {32'h0, a_err, a_cnt}, {32'h0, 16'd0, 16'd4});

      // DONE holds and refuses products.
      a_oval = 1'b1; a_omsg = 32'h0;
      tick(); tick();
      a_oval = 1'b0;
      check("done_hold", {61'h0, a_done, a_ordy, a_ival}, 64'h4);
      check("done_no_accept", {48'h0, a_cnt}, 64'd4);

      // Run 2: restart from DONE, corrupt message 2.
      push_run(32'h2, 32'h3, 4);
      a_go = 1'b1; tick(); a_go = 1'b0;
      check("restart_clear", {31'h0, a_done, a_err, a_cnt}, 64'h0);
      a_xact(32'h0, 0, 1'b0);
      a_xact(32'h1, 0, 1'b0);
      a_xact(32'h0, 0, 1'b0);
      a_xact(32'h0, 0, 1'b0);
      check("run2_done", {62'h0, a_done, a_pass}, 64'h2);
      check("run2_counts", {32'h0, a_err, a_cnt}, {32'h0, 16'd1, 16'd4});

      // Reset while WAIT has a product pending.
      a_go = 1'b1; tick(); a_go = 1'b0;
      a_irdy = 1'b1; tick(); a_irdy = 1'b0;
      check("pre_rst_wait", {62'h0, a_ival, a_ordy}, 64'h1);
      a_oval = 1'b1; a_omsg = 32'h6;
      reset = 1'b1;
      #1;
      check("midrst_flags", {60'h0, a_ival, a_ordy, a_done, a_pass}, 64'h0);
      check("midrst_imsg", a_imsg, 64'h0);
      check("midrst_counts", {32'h0, a_err, a_cnt}, 64'h0);
      tick(); tick();
      reset = 1'b0;
      a_oval = 1'b0;
      tick();
      check("post_rst_idle", {61'h0, a_ival, a_done, a_ordy}, 64'h0);
      push_run(32'h2, 32'h3, 4);
      a_go = 1'b1; tick(); a_go = 1'b0;
      check("replay_first", a_imsg, 64'h0000_0002_0000_0003);
      for (int i = 0; i < 4; i++) a_xact(32'h0, 0, 1'b0);
      check("replay_done", {62'h0, a_done, a_pass}, 64'h3);
      check("replay_cnt", {48'h0, a_cnt}, 64'd4);

      // Instance B: SINK_DELAY=5, product held valid from the cycle after the request.
      b_go = 1'b1; tick(); b_go = 1'b0;
      check("b_val", {63'h0, b_ival}, 64'h1);
      check("b_req", b_imsg, 64'h0000_0002_0000_0003);
      b_irdy = 1'b1; tick(); b_irdy = 1'b0;
      b_oval = 1'b1; b_omsg = 32'd6;
      for (int k = 0; k < 5; k++) begin
         check("b_rdy_low", {47'h0, b_ordy, b_cnt}, 64'h0);
         tick();
      end
      check("b_rdy_high", {47'h0, b_ordy, b_cnt}, 64'h1_0000);
      tick();
      b_oval = 1'b0;
      check("b_done", {61'h0, b_done, b_pass, b_ordy}, 64'h6);
      check("b_counts", {32'h0, b_err, b_cnt}, {32'h0, 16'd0, 16'd1});

      // Instance B rerun: responder answers 7 after 3 cycles of latency.
      b_go = 1'b1; tick(); b_go = 1'b0;
      check("b_clear", {31'h0, b_done, b_err, b_cnt}, 64'h0);
      b_irdy = 1'b1; tick(); b_irdy = 1'b0;
      tick(); tick(); tick();
      b_oval = 1'b1; b_omsg = 32'd7;
      for (int k = 0; k < 20 && !b_done; k++) tick();
      b_oval = 1'b0;
      check("b_bad_done", {62'h0, b_done, b_pass}, 64'h2);
      check("b_bad_counts", {32'h0, b_err, b_cnt}, {32'h0, 16'd1, 16'd1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lab1_imul_stream_driver.md
# lab1_imul_stream_driver

Synthesizable initiator/sink for the lab1 multiplier's istream/ostream val/rdy interface. It issues a configurable number of operand pairs {a,b} from two LFSRs and accepts each product. It checks every product against a*b (low 32 bits) and reports pass/fail status. The block sits beside any lab1_imul_IntMul* variant for on-chip or FPGA self-test, and applies programmable sink backpressure.

## Interface
- NUM_MSGS, 16: transactions per run (≥1)
- A_SEED, 32'h0000_0002: LFSR seed for operand a (0 is replaced by 1)
- B_SEED, 32'h0000_0003: LFSR seed for operand b (0 is replaced by 1)
- SINK_DELAY, 0: cycles ostream_rdy is held low after entering WAIT (0–255)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- go  in  1  start pulse; sampled only in IDLE or DONE
- istream_val  out  1  request valid to multiplier
- istream_rdy  in  1  multiplier ready for request
- istream_msg  out  64  {a[31:0], b[31:0]}
- ostream_val  in  1  product valid from multiplier
- ostream_rdy  out  1  driver ready for product
- ostream_msg  in  32  product
- done  out  1  run complete (level, held)
- pass  out  1  done && err_count==0
- err_count  out  16  mismatches this run, saturating at 16'hFFFF
- msg_count  out  16  products accepted this run

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - On go, load LFSRs with seeds, clear counts, and go to SEND.
- SEND:
  - istream_val=1 and istream_msg={lfsr_a,lfsr_b}.
  - On istream_val&&istream_rdy: capture exp = (lfsr_a*lfsr_b)[31:0].
  - In the same edge: step both LFSRs, load dly=SINK_DELAY, and go to WAIT.
- WAIT:
  - istream_val=0.
  - If dly≠0, decrement dly and hold ostream_rdy=0; ostream_rdy=1 when dly==0.
  - On ostream_val&&ostream_rdy: msg_count++, and err_count++ (saturating) if ostream_msg≠exp.
  - If msg_count+1==NUM_MSGS go to DONE, else go to SEND.
- DONE:
  - done=1, with pass valid.
  - go restarts the run as from IDLE: reseed and clear counts.
- LFSR step: next = {1'b0,x[31:1]} ^ (x[0] ? 32'h8020_0003 : 0).
- Exactly one request is outstanding at a time.
- ostream_rdy is 0 in every state except WAIT with dly==0. A product offered in SEND, IDLE or DONE is not accepted.
- go outside IDLE/DONE is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - istream_val, ostream_rdy, done, pass = 0.
  - istream_msg, err_count, msg_count = 0.
- go sampled at edge N → istream_val=1 from edge N+1.
- Request handshake at edge M → istream_val=0 and ostream_rdy=(SINK_DELAY==0) after M. With SINK_DELAY=d>0, ostream_rdy rises after edge M+d.
- Product handshake at edge P → the next request is valid after P (zero bubble), or done=1 after P on the last message.
- istream_msg is stable while istream_val=1 and istream_rdy=0.
- Reset asserted mid-run immediately forces the reset values, including during a pending handshake. No partial counts survive.
- All outputs are registered or decoded from state; there are no combinational paths from istream_rdy or ostream_val to outputs.

## Structure
- Package lab1_imul_driver_pkg holds:
  - state enum (IDLE/SEND/WAIT/DONE)
  - LFSR_POLY = 32'h8020_0003
  - function lfsr32_next
- One sub-module, lab1_imul_lfsr32 (load, step, seed, q), instantiated twice for a and b.
- The 32×32 product for exp is behavioural * on registered operands. The synthesis multi-cycle constraint is outside this block.
- Implement display_trace (FSM state, istream/ostream handshake marks, exp vs msg) so the driver appears in the existing line-trace output.

## Test plan
- NUM_MSGS=1, seeds 2/3, bench mock responder with 3-cycle latency:
  - go → istream_msg=64'h0000_0002_0000_0003.
  - Responder returns 6 → done=1, pass=1, err_count=0, msg_count=1.
- NUM_MSGS=4, connected to lab1_imul_IntMulBase → done=1, pass=1, msg_count=4.
  - The second request equals {lfsr32_next(2), lfsr32_next(3)} = {32'h0000_0001, 32'h8020_0002}.
- Mock responder returns 7 instead of 6 on message 1 (NUM_MSGS=1) → err_count=1, pass=0, done=1.
- SINK_DELAY=5, mock holds ostream_val=1 from the cycle after the request:
  - ostream_rdy=0 for exactly 5 cycles, then 1.
  - The product is accepted on the 6th cycle.
  - The product is not accepted early.
- Mock holds istream_rdy=0 for 10 cycles in SEND → istream_val stays 1 and istream_msg stays constant; no LFSR step.
- Reset pulsed while in WAIT → all outputs 0 and state IDLE. A following go replays the seed-2/3 sequence from the start.
